cache_port_arbiter: RTL

Two-requester arbiter placed in front of the single-ported blocking data cache (valid/ready/output_valid/hit handshake). Port 0 is the instruction-fetch side and port 1 is the load/store side of the pipelined CPU. The block grants the cache to one requester at a time using round-robin priority. It latches the granted request and holds it on the cache until the cache reports completion, including multi-cycle miss/writeback sequences. It also keeps per-port saturating wait-cycle counters for performance analysis.

---
 rtl/cache_port_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one blocking data cache between instruction-fetch (port 0)
// and load/store (port 1) requesters, with per-port saturating wait-cycle counters.
module cache_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_valid,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic                  p0_mem_read,
  input  logic                  p0_mem_write,
  input  logic [DATA_WIDTH-1:0] p0_din,
  input  logic                  p1_valid,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic                  p1_mem_read,
  input  logic                  p1_mem_write,
  input  logic [DATA_WIDTH-1:0] p1_din,
  output logic                  p0_accept,
  output logic                  p1_accept,
  output logic                  p0_done,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p0_dout,
  output logic [DATA_WIDTH-1:0] p1_dout,
  output logic                  cache_is_input_valid,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_mem_read,
  output logic                  cache_mem_write,
  output logic [DATA_WIDTH-1:0] cache_din,
  input  logic                  cache_is_ready,
  input  logic                  cache_is_output_valid,
  input  logic [DATA_WIDTH-1:0] cache_dout,
  output logic [CNT_WIDTH-1:0]  wait_cycles_p0,
  output logic [CNT_WIDTH-1:0]  wait_cycles_p1
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0]            state, state_nxt;
  logic                  last_grant, last_grant_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_rd, lat_wr;
  logic [DATA_WIDTH-1:0] lat_din;
  logic                  latch_en;
  logic                  sel_port;
  logic                  req0, req1;

  // A request carrying neither read nor write is never a request.
  assign req0 = p0_valid & (p0_mem_read | p0_mem_write);
  assign req1 = p1_valid & (p1_mem_read | p1_mem_write);

  // Arbitration, cache drive and completion; everything is quiet while reset is high.
  always_comb begin
    state_nxt            = state;
    last_grant_nxt       = last_grant;
    latch_en             = 1'b0;
    sel_port             = 1'b0;
    p0_accept            = 1'b0;
    p1_accept            = 1'b0;
    p0_done              = 1'b0;
    p1_done              = 1'b0;
    p0_dout              = '0;
    p1_dout              = '0;
    cache_is_input_valid = 1'b0;
    cache_addr           = '0;
    cache_mem_read       = 1'b0;
    cache_mem_write      = 1'b0;
    cache_din            = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (cache_is_ready && (req0 || req1)) begin
            sel_port             = (req0 && req1) ? ~last_grant : req1;
            p0_accept            = ~sel_port;
            p1_accept            = sel_port;
            cache_is_input_valid = 1'b1;
            cache_addr           = sel_port ? p1_addr      : p0_addr;
            cache_mem_read       = sel_port ? p1_mem_read  : p0_mem_read;
            cache_mem_write      = sel_port ? p1_mem_write : p0_mem_write;
            cache_din            = sel_port ? p1_din       : p0_din;
            if (cache_is_output_valid) begin
              p0_done        = ~sel_port;
              p1_done        = sel_port;
              p0_dout        = sel_port ? '0 : cache_dout;
              p1_dout        = sel_port ? cache_dout : '0;
              last_grant_nxt = sel_port;
            end else begin
              latch_en  = 1'b1;
              state_nxt = sel_port ? GRANT1 : GRANT0;
            end
          end
        end
        GRANT0, GRANT1: begin
          sel_port             = (state == GRANT1);
          cache_is_input_valid = 1'b1;
          cache_addr           = lat_addr;
          cache_mem_read       = lat_rd;
          cache_mem_write      = lat_wr;
          cache_din            = lat_din;
          if (cache_is_output_valid) begin
            p0_done        = ~sel_port;
            p1_done        = sel_port;
            p0_dout        = sel_port ? '0 : cache_dout;
            p1_dout        = sel_port ? cache_dout : '0;
            last_grant_nxt = sel_port;
            state_nxt      = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_addr   <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      lat_din    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (latch_en) begin
        lat_addr <= cache_addr;
        lat_rd   <= cache_mem_read;
        lat_wr   <= cache_mem_write;
        lat_din  <= cache_din;
      end
    end
  end

  // Wait counters: pending, not taken, and not the port currently owning the cache.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cycles_p0 <= '0;
      wait_cycles_p1 <= '0;
    end else begin
      if (req0 && !p0_accept && state != GRANT0 && wait_cycles_p0 != '1)
        wait_cycles_p0 <= wait_cycles_p0 + CNT_WIDTH'(1);
      if (req1 && !p1_accept && state != GRANT1 && wait_cycles_p1 != '1)
        wait_cycles_p1 <= wait_cycles_p1 + CNT_WIDTH'(1);
    end
  end

endmodule
